// File: rtl/alu_result_merger_pkg.sv
// Shared types and constants for the ALU result merger.
package alu_result_merger_pkg;

  // Source indices into the merger's input vectors
  localparam int ALU_RES_INT    = 0;
  localparam int ALU_RES_MULDIV = 1;
  localparam int ALU_RES_DOT8   = 2;

  // One flattened result beat: payload plus writeback tag (64 bits total)
  typedef struct packed {
    logic [23:0] data;
    logic [7:0]  uuid;
    logic [3:0]  wid;
    logic [3:0]  tmask;
    logic [15:0] PC;
    logic        wb;
    logic [4:0]  rd;
    logic [1:0]  pid;
  } alu_result_t;

  // Arbiter state: free to rotate, or pinned to one source mid-packet
  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Source-index width; never zero even for a single source
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_merge_skid_buf.sv
// 2-entry registered FIFO between the merger arbiter and the output.
// space depends on registered occupancy only, so downstream ready never
// reaches the upstream ready path combinationally.
module alu_merge_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             space,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign space  = ~r_count[1];
  assign valid  = (r_count != 2'd0);
  assign data   = r_mem[r_rd_ptr];
  assign w_push = push & space;
  assign w_pop  = pop & valid;

  // Storage: written on push, no reset needed (qualified by count)
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_merger.sv
// Merges the ALU sub-unit result streams into one commit stream.
// Arbitration is round-robin per packet: once an eop=0 beat is taken from a
// source, only that source is served until its eop beat is accepted.
module alu_result_merger
  import alu_result_merger_pkg::*;
#(
  parameter int NUM_INPUTS = 3,
  parameter int DATA_WIDTH = 64,
  parameter int SEL_BITS   = sel_bits(NUM_INPUTS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_INPUTS-1:0]                in_valid,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]                in_sop,
  input  logic [NUM_INPUTS-1:0]                in_eop,
  output logic [NUM_INPUTS-1:0]                in_ready,
  output logic                                 out_valid,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic                                 out_sop,
  output logic                                 out_eop,
  output logic [SEL_BITS-1:0]                  out_sel,
  input  logic                                 out_ready
);

  localparam int BUF_W = DATA_WIDTH + 2 + SEL_BITS;

  arb_state_e            r_state;
  logic [SEL_BITS-1:0]   r_lock_src;
  logic [SEL_BITS-1:0]   r_rr_ptr;

  logic [NUM_INPUTS-1:0] w_req;
  logic                  w_found;
  logic [SEL_BITS-1:0]   w_gidx;
  logic                  w_space;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_gdata;
  logic                  w_gsop;
  logic                  w_geop;
  logic [SEL_BITS-1:0]   w_next_ptr;
  logic [BUF_W-1:0]      w_push_data;
  logic [BUF_W-1:0]      w_buf_data;
  logic                  w_buf_valid;

  // Eligible requesters: everyone when idle, only the owner when locked
  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      w_req[i] = in_valid[i] & ((r_state == ARB_IDLE) || (int'(r_lock_src) == i));
  end

  // Round-robin pick: lowest requester at/after rr_ptr, else lowest below it
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (w_req[i] && (i < int'(r_rr_ptr))) begin
        w_found = 1'b1;
        w_gidx  = SEL_BITS'(i);
      end
    end
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (w_req[i] && (i >= int'(r_rr_ptr))) begin
        w_found = 1'b1;
        w_gidx  = SEL_BITS'(i);
      end
    end
  end

  assign w_accept   = w_found & w_space;
  assign w_next_ptr = (int'(w_gidx) == NUM_INPUTS - 1) ? '0 : w_gidx + 1'b1;

  // One-hot ready and the granted beat's payload
  always_comb begin
    in_ready = '0;
    w_gdata  = '0;
    w_gsop   = 1'b0;
    w_geop   = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (w_accept && (w_gidx == SEL_BITS'(i))) begin
        in_ready[i] = 1'b1;
        w_gdata     = in_data[i];
        w_gsop      = in_sop[i];
        w_geop      = in_eop[i];
      end
    end
  end

  // Lock FSM and rotation pointer; both hold when nothing is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ARB_IDLE;
      r_lock_src <= '0;
      r_rr_ptr   <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= w_next_ptr;
      if (w_geop) begin
        r_state <= ARB_IDLE;
      end else begin
        r_state    <= ARB_LOCKED;
        r_lock_src <= w_gidx;
      end
    end
  end

  assign w_push_data = {w_gidx, w_gsop, w_geop, w_gdata};

  alu_merge_skid_buf #(
    .WIDTH (BUF_W)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (w_accept),
    .push_data (w_push_data),
    .space     (w_space),
    .pop       (out_ready),
    .valid     (w_buf_valid),
    .data      (w_buf_data)
  );

  assign out_valid = w_buf_valid;
  assign out_data  = w_buf_data[DATA_WIDTH-1:0];
  assign out_eop   = w_buf_data[DATA_WIDTH];
  assign out_sop   = w_buf_data[DATA_WIDTH+1];
  assign out_sel   = (NUM_INPUTS == 1) ? '0 : w_buf_data[BUF_W-1 -: SEL_BITS];

  // Protocol checks (simulation)
  a_rdy_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(in_ready))
    else $error("in_ready has more than one bit set");

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_chk
    a_valid_hold: assert property (@(posedge clk) disable iff (reset)
      (in_valid[g] && !in_ready[g]) |=> in_valid[g])
      else $error("source %0d dropped valid before accept", g);
    a_lock_excl: assert property (@(posedge clk) disable iff (reset)
      ((r_state == ARB_LOCKED) && (int'(r_lock_src) != g)) |-> !in_ready[g])
      else $error("source %0d accepted while another source holds the lock", g);
  end

endmodule

// File: doc/alu_result_merger.md
Name: alu_result_merger

Overview:
- Downstream neighbour of the ALU sub-units (integer, muldiv, dot8). Merges their result streams into the single result stream that feeds ALU commit/writeback.
- Arbitrates per packet, not per beat. A multi-beat instruction result (sop..eop, one beat per pid) from one sub-unit is never interleaved with beats from another.
- Registered output through a 2-entry skid buffer. No combinational path from out_ready to in_ready.

Parameters:
- NUM_INPUTS, 3, number of result sources (index 0 = int ALU, 1 = muldiv, 2 = dot8); legal range 1..8.
- DATA_WIDTH, 64, width of one flattened result beat (data plus tag: uuid, wid, tmask, PC, wb, rd, pid).
- SEL_BITS, `UP(`CLOG2(NUM_INPUTS)), width of the source index.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  NUM_INPUTS  per-source beat valid
- in_data  in  NUM_INPUTS x DATA_WIDTH  per-source beat payload
- in_sop  in  NUM_INPUTS  beat is first of packet
- in_eop  in  NUM_INPUTS  beat is last of packet
- in_ready  out  NUM_INPUTS  per-source accept; at most one bit high per cycle
- out_valid  out  1  merged beat valid
- out_data  out  DATA_WIDTH  merged payload
- out_sop  out  1  merged sop
- out_eop  out  1  merged eop
- out_sel  out  SEL_BITS  source index of the current output beat
- out_ready  in  1  downstream accept

Behaviour:
- Clocking and reset: one clock (clk). reset is synchronous and active-high. All state updates on posedge clk.
- Reset values: out_valid=0; out_data, out_sop, out_eop and out_sel are don't-care while out_valid=0. Skid buffer is emptied, lock cleared, round-robin pointer set to 0.
- Beat transfers:
  - Input i transfers when in_valid[i] & in_ready[i].
  - The output transfers when out_valid & out_ready.
  - A source holds valid and all payload fields stable until its beat is accepted.
- Latency: an accepted input beat appears on out_* in the next cycle if the buffer is empty. Sustained throughput is 1 beat/cycle with out_ready=1.
- Skid buffer:
  - 2 entries.
  - buf_space = (count<2) or (count==2 and an output transfer happens this cycle)? No: space is registered.
  - space = count<2, computed from registers only.
  - in_ready is nonzero only when space=1.
- Arbiter state machine:
  - IDLE (unlocked):
    - Grant goes to the first requesting input at or after rr_ptr, wrapping modulo NUM_INPUTS.
    - On accepting a beat with eop=0, go to LOCKED(src) and hold src.
    - On accepting a beat with eop=1, stay in IDLE.
    - After any accepted beat, rr_ptr = (src+1) mod NUM_INPUTS; the wrap from NUM_INPUTS-1 goes to 0.
  - LOCKED(src):
    - Only src may be granted. All other in_ready bits are 0 even when they request.
    - Accepting a beat from src with eop=1 returns to IDLE.
    - rr_ptr updates on that final beat only.
- sop handling: sop is passed through and not checked. A lock is entered on any accepted eop=0 beat, including a non-sop beat.
- No requests: no grant, and rr_ptr holds.
- Buffer full: all in_ready=0. Lock state and rr_ptr hold.
- Simultaneous push and pop on a full buffer: the push is not allowed in that cycle.
- Reset mid-packet: lock is dropped and buffered beats are discarded. The bench must treat the partial packet as lost.
- NUM_INPUTS=1: the arbiter degenerates to a pass-through. out_sel is tied to 0.
- Assertions, simulation only:
  - in_ready is one-hot or zero.
  - The valid of a source that has not been accepted never drops.
  - In LOCKED(src), no beat is accepted from any other source.

Decomposition:
- Shared package (VX_gpu_pkg additions):
  - alu_result_t packed struct (data, uuid, wid, tmask, PC, wb, rd, pid).
  - Named source-index constants ALU_RES_INT=0, ALU_RES_MULDIV=1, ALU_RES_DOT8=2.
- One sub-module: alu_merge_skid_buf, a 2-entry registered FIFO.
  - Width DATA_WIDTH+2+SEL_BITS.
  - Ports: push/space/pop/valid.
- The arbiter and lock FSM live in the top.

Test Plan:
- Single source: input 2 sends 4 single-beat packets (sop=eop=1, data 0x11..0x44) with out_ready=1 -> out beats 0x11,0x22,0x33,0x44 on consecutive cycles, first one cycle after the first accept, out_sel=2.
- Round-robin: all 3 inputs continuously valid with single-beat packets, rr_ptr=0 after reset -> grant order 0,1,2,0,1,2. Each source gets exactly 1/3 of beats over 30 cycles.
- Packet lock: input 1 sends a 4-beat packet (pid 0..3, eop on pid 3) while input 0 is continuously valid -> output shows the 4 beats from source 1 contiguously. Input 0 is granted on the cycle after the eop accept.
- Backpressure: out_ready=0 for 5 cycles while input 0 streams -> exactly 2 beats accepted, then in_ready=0. After out_ready=1, there is no loss, duplication or reorder of 10 beats.
- Reset mid-packet: assert reset after beat 2 of a 4-beat packet from input 2 -> next cycle out_valid=0, no lock. Input 0 is granted first (rr_ptr=0) after reset deasserts.
- Wrap-around: rr_ptr=2 after an input-1 grant, with inputs 0 and 2 valid -> grant 2 then 0.
